// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and defaults for the load/store unit
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int TIMEOUT_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
        return size == SZ_BYTE ? 1'b1 : size == SZ_HALF ? ~addr[0] : addr == 2'b00;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable/write-data steering, misalignment check and load data shift/extend
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    input  logic [1:0]  rsize,
    input  logic [1:0]  raddr,
    input  logic        runsigned,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdext,
    output logic        misaligned
);
    logic [31:0] shifted;
    always_comb begin
        misaligned = ~is_aligned(size, addr);
        be = size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = size == SZ_BYTE ? {4{wd[7:0]}} : size == SZ_HALF ? {2{wd[15:0]}} : wd;
        shifted = rdata >> {raddr, 3'b000};
        rdext = rsize == SZ_BYTE ? {{24{~runsigned & shifted[7]}}, shifted[7:0]}
              : rsize == SZ_HALF ? {{16{~runsigned & shifted[15]}}, shifted[15:0]}
              : shifted;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit driving a req/ack data bus and stalling the pipeline
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        unsignedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic [31:0] addr_r, wdata_r, rdata_r, wdata_c, rdext;
    logic [3:0]  be_r, be_c;
    logic [1:0]  size_r;
    logic        uns_r, we_r, mis, valid, idle, in_req, tmo;
    logic [CW-1:0] cnt;
    lsu_align u_align (
        .size(sizeM), .addr(aluoutM[1:0]), .wd(writedataM),
        .rsize(size_r), .raddr(addr_r[1:0]), .runsigned(uns_r), .rdata(bus_rdata),
        .be(be_c), .wdata(wdata_c), .rdext(rdext), .misaligned(mis)
    );
    assign idle   = state == IDLE;
    assign in_req = state == REQ;
    assign valid  = (memreadM | memwriteM) & ~mis;
    assign tmo    = in_req & ~bus_ack & (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = idle ? (valid ? REQ : IDLE) : in_req ? ((bus_ack | tmo) ? DONE : REQ) : IDLE;
    end
    always_comb begin
        bus_req   = in_req;
        bus_we    = in_req & we_r;
        bus_err   = tmo;
        stallM    = ~rst & (in_req | (idle & valid));
        adelM     = ~rst & idle & memreadM & ~memwriteM & mis;
        adesM     = ~rst & idle & memwriteM & mis;
        bus_addr  = {addr_r[31:2], 2'b00};
        bus_be    = be_r;
        bus_wdata = wdata_r;
        readdataM = rdata_r;
    end
    // Request attributes are latched at IDLE detect so the bus sees stable values through REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            be_r    <= '0;
            size_r  <= SZ_BYTE;
            uns_r   <= 1'b0;
            we_r    <= 1'b0;
            cnt     <= '0;
        end else begin
            if (idle & valid) begin
                addr_r  <= aluoutM;
                wdata_r <= wdata_c;
                be_r    <= be_c;
                size_r  <= sizeM;
                uns_r   <= unsignedM;
                we_r    <= memwriteM;
            end
            cnt <= in_req ? cnt + 1'b1 : '0;
            if (in_req & bus_ack & ~we_r) rdata_r <= rdext;
            else if (tmo) rdata_r <= '0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-vector self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_pkg::*;
    logic        clk, rst, memreadM, memwriteM, unsignedM, bus_ack;
    logic [1:0]  sizeM;
    logic [31:0] aluoutM, writedataM, bus_rdata;
    logic [31:0] readdataM, bus_addr, bus_wdata;
    logic        stallM, adelM, adesM, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] o_addr, o_be, o_wdata, o_we, o_rd, o_err;
    int stalls;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM),
        .unsignedM(unsignedM), .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
        .stallM(stallM), .adelM(adelM), .adesM(adesM), .bus_err(bus_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ack is held high whenever bus_req is low, so any sampling of it outside REQ shows up
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                              input int ack_delay);
        int reqn;
        logic seen, done;
        reqn = 0; seen = 0; done = 0; stalls = 0; o_err = 0;
        o_addr = 'x; o_be = 'x; o_wdata = 'x; o_we = 'x; o_rd = 'x;
        @(negedge clk);
        memreadM = rd; memwriteM = wr; sizeM = sz; unsignedM = uns;
        aluoutM = a; writedataM = wd; bus_rdata = rdata; bus_ack = 1;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus_req) begin
                bus_ack = ack_delay >= 0 && reqn == ack_delay;
                reqn++;
            end else bus_ack = 1;
            #1;
            if (stallM) stalls++;
            if (bus_err) o_err++;
            if (bus_req) begin
                o_addr = bus_addr; o_be = {28'd0, bus_be}; o_wdata = bus_wdata; o_we = {31'd0, bus_we};
                seen = 1;
            end else if (seen && !stallM) begin
                o_rd = readdataM;
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        memreadM = 0; memwriteM = 0; bus_ack = 0;
        if (!done) check("access_bound", 0, 1);
    endtask

    initial begin
        rst = 1; memreadM = 0; memwriteM = 0; sizeM = SZ_WORD; unsignedM = 0;
        aluoutM = 0; writedataM = 0; bus_rdata = 0; bus_ack = 0;
        #12;
        check("rst_req", {31'd0, bus_req}, 0);
        check("rst_stall", {31'd0, stallM}, 0);
        check("rst_err", {31'd0, bus_err}, 0);
        check("rst_rd", readdataM, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", {28'd0, bus_be}, 0);
        @(negedge clk); rst = 0;

        run_access(1, 0, SZ_WORD, 0, 32'h100, 0, 32'hDEADBEEF, 0);
        check("lw_addr", o_addr, 32'h100);
        check("lw_be", o_be, 4'hF);
        check("lw_we", o_we, 0);
        check("lw_stalls", stalls, 2);
        check("lw_rd", o_rd, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("lw_hold", readdataM, 32'hDEADBEEF);

        run_access(1, 0, SZ_BYTE, 0, 32'h203, 0, 32'h80FF1234, 0);
        check("lb_be", o_be, 4'h8);
        check("lb_rd", o_rd, 32'hFFFFFF80);
        run_access(1, 0, SZ_BYTE, 1, 32'h203, 0, 32'h80FF1234, 0);
        check("lbu_rd", o_rd, 32'h00000080);

        run_access(1, 0, SZ_HALF, 0, 32'h2, 0, 32'h80017FFF, 1);
        check("lh_be", o_be, 4'hC);
        check("lh_stalls", stalls, 3);
        check("lh_rd", o_rd, 32'hFFFF8001);

        run_access(0, 1, SZ_HALF, 0, 32'h302, 32'h0000ABCD, 32'h11111111, 0);
        check("sh_we", o_we, 1);
        check("sh_be", o_be, 4'hC);
        check("sh_wdata", o_wdata, 32'hABCDABCD);
        check("sh_addr", o_addr, 32'h300);
        check("sh_rd_keep", o_rd, 32'hFFFF8001);

        run_access(0, 1, SZ_BYTE, 0, 32'h1, 32'h1234565A, 0, 0);
        check("sb_be", o_be, 4'h2);
        check("sb_wdata", o_wdata, 32'h5A5A5A5A);

        @(negedge clk);
        memreadM = 1; sizeM = SZ_HALF; aluoutM = 32'h101; bus_ack = 1;
        #1;
        check("adel", {31'd0, adelM}, 1);
        check("adel_ades", {31'd0, adesM}, 0);
        check("adel_stall", {31'd0, stallM}, 0);
        @(negedge clk); #1;
        check("adel_req", {31'd0, bus_req}, 0);
        memreadM = 0; memwriteM = 1; sizeM = SZ_WORD; aluoutM = 32'h102;
        #1;
        check("ades", {31'd0, adesM}, 1);
        check("ades_adel", {31'd0, adelM}, 0);
        check("ades_stall", {31'd0, stallM}, 0);
        memwriteM = 0; bus_ack = 0;

        run_access(1, 0, SZ_WORD, 0, 32'h40, 0, 32'hCAFEF00D, -1);
        check("tmo_err", o_err, 1);
        check("tmo_stalls", stalls, TIMEOUT_DEFAULT + 1);
        check("tmo_rd", o_rd, 0);
        run_access(1, 0, SZ_WORD, 0, 32'h44, 0, 32'h0BADC0DE, 0);
        check("post_tmo_rd", o_rd, 32'h0BADC0DE);

        @(negedge clk);
        memreadM = 1; sizeM = SZ_WORD; aluoutM = 32'h80; bus_ack = 0;
        @(negedge clk); #1;
        check("rst_mid_req", {31'd0, bus_req}, 1);
        #2 rst = 1;
        #1;
        check("rst_mid_req_drop", {31'd0, bus_req}, 0);
        check("rst_mid_stall_drop", {31'd0, stallM}, 0);
        memreadM = 0;
        @(negedge clk); rst = 0;
        run_access(1, 0, SZ_WORD, 0, 32'h0, 0, 32'h12345678, 0);
        check("post_rst_addr", o_addr, 0);
        check("post_rst_rd", o_rd, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
